// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if: groups the two requester ports and the Data_Memory port
// of the arbiter into one bundle. The arbiter binds the slave modport.
// The requester/memory side (CPU path, debug loader, Data_Memory) binds master.
//   P0_* : CPU load/store requester      P1_* : debug/loader requester
//   DM_* : Data_Memory address/data/write-enable and combinational read data
//   Busy : arbiter is sequencing an access
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Requester 0 (CPU)
  logic              P0_Req;
  logic              P0_Write;
  logic [ADDR_W-1:0] P0_Addr;
  logic [DATA_W-1:0] P0_WData;
  logic              P0_Ack;
  logic [DATA_W-1:0] P0_RData;

  // Requester 1 (debug/loader)
  logic              P1_Req;
  logic              P1_Write;
  logic [ADDR_W-1:0] P1_Addr;
  logic [DATA_W-1:0] P1_WData;
  logic              P1_Ack;
  logic [DATA_W-1:0] P1_RData;

  // Data_Memory side
  logic [ADDR_W-1:0] DM_Input_Address;
  logic [DATA_W-1:0] DM_Data_To_Write;
  logic              DM_Write_Enable_Flag;
  logic [DATA_W-1:0] DM_Output_Data;

  // Status
  logic              Busy;

  // Arbiter view
  modport slave (
    input  P0_Req, P0_Write, P0_Addr, P0_WData,
    input  P1_Req, P1_Write, P1_Addr, P1_WData,
    input  DM_Output_Data,
    output P0_Ack, P0_RData,
    output P1_Ack, P1_RData,
    output DM_Input_Address, DM_Data_To_Write, DM_Write_Enable_Flag,
    output Busy
  );

  // Requester / memory view
  modport master (
    output P0_Req, P0_Write, P0_Addr, P0_WData,
    output P1_Req, P1_Write, P1_Addr, P1_WData,
    output DM_Output_Data,
    input  P0_Ack, P0_RData,
    input  P1_Ack, P1_RData,
    input  DM_Input_Address, DM_Data_To_Write, DM_Write_Enable_Flag,
    input  Busy
  );

endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one Data_Memory port between P0 (CPU) and P1 (debug/loader).
// Latency: Req sampled at an IDLE edge -> memory access next cycle -> one-cycle Ack the cycle after.
// Backpressure: requesters hold Req/Addr/WData/Write until Ack; the loser simply waits (one access per 3 cycles).
// Ports:
//   CLK      : system clock, rising edge
//   RST      : synchronous active-high reset
//   bus      : dm_port_arbiter_if.slave (P0_*/P1_* requesters, DM_* memory port, Busy)
// Parameters:
//   ADDR_W / DATA_W : address / data widths
//   FIXED_PRIO      : 0 = round-robin between ports, 1 = P0 always wins ties
module dm_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  dm_port_arbiter_if.slave    bus
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Port identifiers used for the latched winner and the round-robin pointer
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic              r_ptr;      // port that wins when both request (round-robin)
  logic              r_id;       // winner of the access in flight
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              w_any_req;
  logic              w_pick_p1;
  logic [1:0]        w_state_nxt;
  logic              w_in_idle;
  logic              w_in_access;
  logic              w_in_resp;
  logic              w_win_write;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_in_resp   = (r_state == ST_RESP);
  assign w_any_req   = bus.P0_Req | bus.P1_Req;

  // Winner selection. With a single requester it always wins; on a tie the
  // pointer decides, or P0 unconditionally when fixed priority is selected.
  always_comb begin
    w_pick_p1 = 1'b0;
    if (bus.P0_Req && bus.P1_Req) begin
      if (FIXED_PRIO) begin
        w_pick_p1 = 1'b0;
      end else begin
        w_pick_p1 = (r_ptr == PORT1);
      end
    end else begin
      w_pick_p1 = bus.P1_Req;
    end
  end

  // Mux the winner's request fields for latching at the IDLE edge
  always_comb begin
    w_win_write = bus.P0_Write;
    w_win_addr  = bus.P0_Addr;
    w_win_wdata = bus.P0_WData;
    if (w_pick_p1) begin
      w_win_write = bus.P1_Write;
      w_win_addr  = bus.P1_Addr;
      w_win_wdata = bus.P1_WData;
    end
  end

  // Next state: IDLE -> ACCESS -> RESP -> IDLE, one cycle each
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_state_nxt = w_any_req ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_ptr    <= PORT0;
      r_id     <= PORT0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Capture the winning request; these stay on the DM port until the
      // next grant so the memory address/data do not toggle while idle.
      if (w_in_idle && w_any_req) begin
        r_id    <= w_pick_p1 ? PORT1 : PORT0;
        r_write <= w_win_write;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
      end

      // Loads: memory read is combinational, so the data is valid during
      // ACCESS and is captured at its closing edge into the winner's register.
      // Stores leave the read-data registers untouched.
      if (w_in_access && !r_write) begin
        if (r_id == PORT1) begin
          r_rdata1 <= bus.DM_Output_Data;
        end else begin
          r_rdata0 <= bus.DM_Output_Data;
        end
      end

      // Round-robin: after serving a port, the other port gets the next tie
      if (w_in_resp && !FIXED_PRIO) begin
        r_ptr <= ~r_id;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.DM_Input_Address = r_addr;
  assign bus.DM_Data_To_Write = r_wdata;

  // RST gates the write strobe combinationally: a reset arriving during
  // ACCESS must stop the store from committing at that same edge.
  assign bus.DM_Write_Enable_Flag = w_in_access & r_write & ~RST;

  // Ack is likewise suppressed by a reset landing in the RESP cycle
  assign bus.P0_Ack = w_in_resp & (r_id == PORT0) & ~RST;
  assign bus.P1_Ack = w_in_resp & (r_id == PORT1) & ~RST;

  assign bus.P0_RData = r_rdata0;
  assign bus.P1_RData = r_rdata1;

  assign bus.Busy = ~w_in_idle;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: vector table + hand sequences + randomized run against a
// transaction-level model, for both round-robin and fixed-priority builds.
module tb_dm_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST;
  logic RST2;
  always #5 CLK = ~CLK;

  dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
  dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) dut (
    .CLK(CLK), .RST(RST), .bus(bus));

  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) dut_fp (
    .CLK(CLK), .RST(RST2), .bus(bus2));

  // Data_Memory for the round-robin instance: combinational read, write on edge
  logic [DW-1:0] mem [16];
  logic          mem_init;
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
    end else if (bus.DM_Write_Enable_Flag) begin
      mem[bus.DM_Input_Address[3:0]] <= bus.DM_Data_To_Write;
    end
  end
  assign bus.DM_Output_Data  = mem[bus.DM_Input_Address[3:0]];
  assign bus2.DM_Output_Data = bus2.DM_Input_Address ^ 32'hA5A5_0000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.P0_Req = r; bus.P0_Write = w; bus.P0_Addr = a; bus.P0_WData = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.P1_Req = r; bus.P1_Write = w; bus.P1_Addr = a; bus.P1_WData = d;
  endtask

  task automatic cyc1();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs driven before an edge, outputs expected after it
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic        r0, w0; logic [31:0] a0, d0;
    logic        r1, w1; logic [31:0] a1, d1;
    logic        busy, we, ack0, ack1;
    logic [31:0] addr, wd, rd0, rd1;
  } vec_t;

  function automatic vec_t mk(
      input logic rst,
      input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
      input logic busy, input logic we, input logic ack0, input logic ack1,
      input logic [31:0] addr, input logic [31:0] wd,
      input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.busy = busy; v.we = we; v.ack0 = ack0; v.ack1 = ack1;
    v.addr = addr; v.wd = wd; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  vec_t tbl[18];

  // Transaction-level reference state for the random run
  logic [31:0] shadow [16];
  logic [31:0] erd [2];
  logic        preq [2];
  logic        pwr  [2];
  logic [31:0] paddr [2];
  logic [31:0] pwd  [2];

  task automatic new_req(input int p);
    preq[p]  = 1'b1;
    pwr[p]   = 1'($urandom_range(0, 1));
    paddr[p] = $urandom_range(0, 15);
    pwd[p]   = $urandom;
  endtask

  initial begin
    int  cyc, free_at, acc_cyc;
    bit  last, mbusy, win, mwr;
    bit  eack [2];
    logic [31:0] maddr, mwd, mrd;

    // ---- prelude: reset both instances, load memory -------------------------
    RST = 1'b1; RST2 = 1'b1; mem_init = 1'b1;
    drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
    bus2.P0_Req = 0; bus2.P0_Write = 0; bus2.P0_Addr = 0; bus2.P0_WData = 0;
    bus2.P1_Req = 0; bus2.P1_Write = 0; bus2.P1_Addr = 0; bus2.P1_WData = 0;
    cyc1();
    mem_init = 1'b0;

    //            rst r0 w0 a0 d0      r1 w1 a1 d1   busy we a0 a1 addr wd rd0 rd1
    tbl[0]  = mk(1, 0,0,0,0,           0,0,0,0,      0,0,0,0, 0,0, 0,0);
    tbl[1]  = mk(1, 0,0,0,0,           0,0,0,0,      0,0,0,0, 0,0, 0,0);
    tbl[2]  = mk(0, 1,1,2,7,           0,0,0,0,      1,1,0,0, 2,7, 0,0);
    tbl[3]  = mk(0, 1,1,2,7,           0,0,0,0,      1,0,1,0, 2,7, 0,0);
    tbl[4]  = mk(0, 0,0,0,0,           0,0,0,0,      0,0,0,0, 2,7, 0,0);
    tbl[5]  = mk(0, 0,0,0,0,           1,0,2,0,      1,0,0,0, 2,0, 0,0);
    tbl[6]  = mk(0, 0,0,0,0,           1,0,2,0,      1,0,0,1, 2,0, 0,7);
    tbl[7]  = mk(0, 0,0,0,0,           0,0,0,0,      0,0,0,0, 2,0, 0,7);
    tbl[8]  = mk(1, 0,0,0,0,           0,0,0,0,      0,0,0,0, 0,0, 0,0);
    tbl[9]  = mk(0, 1,0,3,0,           1,0,4,0,      1,0,0,0, 3,0, 0,0);
    tbl[10] = mk(0, 1,0,3,0,           1,0,4,0,      1,0,1,0, 3,0, 32'h103,0);
    tbl[11] = mk(0, 1,0,5,0,           1,0,4,0,      0,0,0,0, 3,0, 32'h103,0);
    tbl[12] = mk(0, 1,0,5,0,           1,0,4,0,      1,0,0,0, 4,0, 32'h103,0);
    tbl[13] = mk(0, 1,0,5,0,           1,0,4,0,      1,0,0,1, 4,0, 32'h103,32'h104);
    tbl[14] = mk(0, 1,0,5,0,           0,0,0,0,      0,0,0,0, 4,0, 32'h103,32'h104);
    tbl[15] = mk(0, 1,0,5,0,           0,0,0,0,      1,0,0,0, 5,0, 32'h103,32'h104);
    tbl[16] = mk(0, 1,0,5,0,           0,0,0,0,      1,0,1,0, 5,0, 32'h105,32'h104);
    tbl[17] = mk(0, 0,0,0,0,           0,0,0,0,      0,0,0,0, 5,0, 32'h105,32'h104);

    for (int i = 0; i < 18; i++) begin
      RST = tbl[i].rst;
      drv0(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
      drv1(tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      cyc1();
      chk($sformatf("row%0d busy", i), bus.Busy,                 tbl[i].busy);
      chk($sformatf("row%0d we",   i), bus.DM_Write_Enable_Flag, tbl[i].we);
      chk($sformatf("row%0d ack0", i), bus.P0_Ack,               tbl[i].ack0);
      chk($sformatf("row%0d ack1", i), bus.P1_Ack,               tbl[i].ack1);
      chk($sformatf("row%0d addr", i), bus.DM_Input_Address,     tbl[i].addr);
      chk($sformatf("row%0d wdat", i), bus.DM_Data_To_Write,     tbl[i].wd);
      chk($sformatf("row%0d rd0",  i), bus.P0_RData,             tbl[i].rd0);
      chk($sformatf("row%0d rd1",  i), bus.P1_RData,             tbl[i].rd1);
    end

    // ---- reset during ACCESS of a P0 store: store must not land --------------
    drv0(1, 1, 1, 32'hFF);
    cyc1();
    chk("rstacc we_pre", bus.DM_Write_Enable_Flag, 1);
    RST = 1'b1;
    #1;
    chk("rstacc we_gated", bus.DM_Write_Enable_Flag, 0);
    cyc1();
    chk("rstacc busy", bus.Busy, 0);
    chk("rstacc ack0", bus.P0_Ack, 0);
    RST = 1'b0;
    drv0(0, 0, 0, 0);
    drv1(1, 0, 1, 0);
    cyc1();
    cyc1();
    chk("rstacc ack1", bus.P1_Ack, 1);
    chk("rstacc old", bus.P1_RData, 32'h101);
    drv1(0, 0, 0, 0);
    cyc1();

    // ---- reset during RESP: Ack suppressed ----------------------------------
    drv1(1, 0, 2, 0);
    cyc1();
    cyc1();
    chk("rstresp ack_pre", bus.P1_Ack, 1);
    RST = 1'b1;
    #1;
    chk("rstresp ack_gated", bus.P1_Ack, 0);
    cyc1();
    RST = 1'b0;
    drv1(0, 0, 0, 0);
    chk("rstresp busy", bus.Busy, 0);

    // ---- fixed priority: P0 continuous starves P1 ---------------------------
    RST2 = 1'b0;
    bus2.P0_Req = 1; bus2.P0_Addr = 8;
    bus2.P1_Req = 1; bus2.P1_Addr = 9;
    for (int n = 1; n <= 15; n++) begin
      cyc1();
      chk($sformatf("fp n%0d ack0", n), bus2.P0_Ack, ((n % 3) == 2) ? 1 : 0);
      chk($sformatf("fp n%0d ack1", n), bus2.P1_Ack, 0);
    end
    bus2.P0_Req = 0;
    for (int n = 16; n <= 18; n++) begin
      cyc1();
      chk($sformatf("fp n%0d ack0", n), bus2.P0_Ack, 0);
      chk($sformatf("fp n%0d ack1", n), bus2.P1_Ack, (n == 17) ? 1 : 0);
      if (n == 17) chk("fp rd1", bus2.P1_RData, 32'h9 ^ 32'hA5A5_0000);
    end
    bus2.P1_Req = 0;

    // ---- randomized traffic vs transaction model ----------------------------
    RST = 1'b1; mem_init = 1'b1;
    drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
    cyc1();
    RST = 1'b0; mem_init = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h100 + i;
    for (int p = 0; p < 2; p++) begin
      erd[p] = 0; preq[p] = 0; pwr[p] = 0; paddr[p] = 0; pwd[p] = 0;
    end
    cyc = 0; free_at = 1; acc_cyc = -10; mbusy = 0; last = 1'b1; win = 0;
    mwr = 0; maddr = 0; mwd = 0; mrd = 0;

    for (int it = 0; it < 900; it++) begin
      drv0(preq[0], pwr[0], paddr[0], pwd[0]);
      drv1(preq[1], pwr[1], paddr[1], pwd[1]);
      // A grant happens at the next edge if the arbiter is free and someone asks;
      // on a tie the port not served most recently goes first.
      if (cyc + 1 >= free_at && (preq[0] || preq[1])) begin
        if (preq[0] && preq[1]) win = ~last;
        else                    win = preq[1];
        mwr   = pwr[win];
        maddr = paddr[win];
        mwd   = pwd[win];
        mrd   = shadow[maddr[3:0]];
        if (mwr) shadow[maddr[3:0]] = mwd;
        acc_cyc = cyc + 1;
        free_at = cyc + 4;
        mbusy   = 1;
      end
      cyc1();
      cyc++;
      eack[0] = mbusy && (cyc == acc_cyc + 1) && (win == 1'b0);
      eack[1] = mbusy && (cyc == acc_cyc + 1) && (win == 1'b1);
      chk($sformatf("rnd c%0d busy", cyc), bus.Busy,
          (mbusy && (cyc == acc_cyc || cyc == acc_cyc + 1)) ? 1 : 0);
      chk($sformatf("rnd c%0d we", cyc), bus.DM_Write_Enable_Flag,
          (mbusy && cyc == acc_cyc && mwr) ? 1 : 0);
      chk($sformatf("rnd c%0d ack0", cyc), bus.P0_Ack, eack[0]);
      chk($sformatf("rnd c%0d ack1", cyc), bus.P1_Ack, eack[1]);
      if (mbusy && cyc == acc_cyc) begin
        chk($sformatf("rnd c%0d addr", cyc), bus.DM_Input_Address, maddr);
        if (mwr) chk($sformatf("rnd c%0d wdat", cyc), bus.DM_Data_To_Write, mwd);
      end
      if (mbusy && cyc == acc_cyc + 1) begin
        if (!mwr) erd[win] = mrd;
        last  = win;
        mbusy = 0;
      end
      chk($sformatf("rnd c%0d rd0", cyc), bus.P0_RData, erd[0]);
      chk($sformatf("rnd c%0d rd1", cyc), bus.P1_RData, erd[1]);
      for (int p = 0; p < 2; p++) begin
        if (eack[p]) begin
          if ($urandom_range(0, 1) == 1) new_req(p);
          else preq[p] = 0;
        end else if (!preq[p] && $urandom_range(0, 3) == 0) begin
          new_req(p);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
